mac_rx_frame_reader: RTL

- Ingress stage directly downstream of the per-port MAC receive path. Consumes the MAC's rx pointer FIFO (one descriptor per frame) and rx data FIFO (one byte per entry).
- Presents each good frame as a byte stream with valid/ready handshake and SOP/EOP markers to the switch ingress/lookup logic.
- Discards errored or illegal-length frames entirely and counts them.

---
 rtl/mac_rx_frame_reader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mac_rx_frame_reader.sv
// mac_rx_frame_reader: pulls one descriptor per frame from the MAC rx pointer
// FIFO, then either streams the frame bytes out through a 2-entry skid buffer
// or silently drains them from the data FIFO when the frame is bad. Only one
// frame is in flight at a time, so SOP/EOP ordering needs no extra tracking.
module mac_rx_frame_reader #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 60,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_sys,
  input  logic             ptr_fifo_empty,
  output logic             ptr_fifo_rd,
  input  logic [15:0]      ptr_fifo_dout,
  output logic             data_fifo_rd,
  input  logic [7:0]       data_fifo_dout,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [7:0]       o_data,
  output logic             o_sop,
  output logic             o_eop,
  output logic [11:0]      o_len,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, PTR_WAIT, DECODE, STREAM, DROP} state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  state_e           state_q, state_d;
  logic [11:0]      len_q, len_d;
  logic             err_q, err_d;
  logic [11:0]      rem_q, rem_d;
  logic [11:0]      olen_q, olen_d;
  logic [11:0]      wr_idx_q, wr_idx_d;
  logic             infl_q, infl_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  beat_t            buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]       occ_q, occ_d;

  logic             ptr_rd_c, data_rd_c;
  logic             push, pop;
  logic [2:0]       slots_used;
  beat_t            new_beat;

  assign o_valid   = (occ_q != 2'd0);
  assign o_data    = buf0_q.data;
  assign o_sop     = o_valid & buf0_q.sop;
  assign o_eop     = o_valid & buf0_q.eop;
  assign o_len     = olen_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

  // Strobes are masked during reset so the FIFOs are never popped while the
  // FSM is being forced back to IDLE.
  assign ptr_fifo_rd  = ptr_rd_c & ~rst_sys;
  assign data_fifo_rd = data_rd_c & ~rst_sys;

  assign push = infl_q;
  assign pop  = o_valid & o_ready;

  // Buffer slots committed after this cycle: entries held plus the byte still
  // in flight, minus the beat leaving now. Counting the departing beat lets a
  // new read issue every cycle while downstream keeps o_ready high.
  assign slots_used = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

  // FSM next-state, FIFO read strobes and counter updates
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    err_d       = err_q;
    rem_d       = rem_q;
    olen_d      = olen_q;
    infl_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ptr_rd_c    = 1'b0;
    data_rd_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ptr_fifo_empty) begin
          ptr_rd_c = 1'b1;
          state_d  = PTR_WAIT;
        end
      end
      PTR_WAIT: begin
        len_d   = ptr_fifo_dout[11:0];
        err_d   = ptr_fifo_dout[15];
        state_d = DECODE;
      end
      DECODE: begin
        if (len_q == 12'd0) begin
          if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
          state_d = IDLE;
        end else if (err_q || (len_q < 12'(MIN_LEN)) || (len_q > 12'(MAX_LEN))) begin
          rem_d   = len_q;
          state_d = DROP;
        end else begin
          rem_d   = len_q;
          olen_d  = len_q;
          state_d = STREAM;
        end
      end
      DROP: begin
        data_rd_c = 1'b1;
        rem_d     = rem_q - 12'd1;
        if (rem_q == 12'd1) begin
          if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      STREAM: begin
        if ((rem_q != 12'd0) && (slots_used < 3'd2)) begin
          data_rd_c = 1'b1;
          infl_d    = 1'b1;
          rem_d     = rem_q - 12'd1;
        end
        // EOP is the final byte, so every read has landed by the time it leaves.
        if (pop && buf0_q.eop) begin
          if (frame_cnt_q != {CNT_W{1'b1}}) frame_cnt_d = frame_cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: byte returning from the data FIFO is tagged with SOP/EOP by
  // its index in the frame, then queued behind the current head.
  always_comb begin
    new_beat.data = data_fifo_dout;
    new_beat.sop  = (wr_idx_q == 12'd0);
    new_beat.eop  = (wr_idx_q == (len_q - 12'd1));
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    occ_d         = occ_q;
    wr_idx_d      = wr_idx_q;
    if (state_q == DECODE) wr_idx_d = 12'd0;
    if (push) wr_idx_d = wr_idx_q + 12'd1;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = new_beat;
        else               buf1_d = new_beat;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = new_beat;
        end else begin
          buf0_d = buf1_q;
          buf1_d = new_beat;
        end
      end
      default: ;
    endcase
  end

  // State, counters and skid buffer registers
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_q     <= IDLE;
      len_q       <= '0;
      err_q       <= 1'b0;
      rem_q       <= '0;
      olen_q      <= '0;
      wr_idx_q    <= '0;
      infl_q      <= 1'b0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      err_q       <= err_d;
      rem_q       <= rem_d;
      olen_q      <= olen_d;
      wr_idx_q    <= wr_idx_d;
      infl_q      <= infl_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      occ_q       <= occ_d;
    end
  end

endmodule
